// File: rtl/tube_pkg.sv
// Shared definitions for the 8-digit multiplexed 7-segment scan bus:
// segment/select codes, decoded symbols, error codes and decoder FSM states.
package tube_pkg;

  localparam logic [7:0] SEG_D0 = 8'hC0;
  localparam logic [7:0] SEG_D1 = 8'hF9;
  localparam logic [7:0] SEG_DM = 8'hBF;

  localparam logic [7:0] SEL_B1 = 8'hFE;
  localparam logic [7:0] SEL_B2 = 8'hFD;
  localparam logic [7:0] SEL_B3 = 8'hFB;
  localparam logic [7:0] SEL_B4 = 8'hF7;
  localparam logic [7:0] SEL_B5 = 8'hEF;
  localparam logic [7:0] SEL_B6 = 8'hDF;
  localparam logic [7:0] SEL_B7 = 8'hBF;
  localparam logic [7:0] SEL_B8 = 8'h7F;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    ONE   = 2'd1,
    MINUS = 2'd2,
    BAD   = 2'd3
  } symbol_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_SEL     = 3'd1,
    ERR_SEG     = 3'd2,
    ERR_ORDER   = 3'd3,
    ERR_FMT     = 3'd4,
    ERR_TIMEOUT = 3'd5
  } err_t;

  typedef enum logic {
    HUNT    = 1'b0,
    CAPTURE = 1'b1
  } fsm_t;

  function automatic symbol_t decode_seg(input logic [7:0] seg);
    symbol_t s;
    case (seg)
      SEG_D0:  s = ZERO;
      SEG_D1:  s = ONE;
      SEG_DM:  s = MINUS;
      default: s = BAD;
    endcase
    return s;
  endfunction

  // Occupied slots always fill from B1 upward, so only thermometer masks are legal.
  function automatic logic slot_mask_ok(input logic [3:0] mask);
    logic ok;
    case (mask)
      4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111: ok = 1'b1;
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/tube_input_filter.sv
// Synchronizes the scan bus, waits for a settled digit and decodes its
// position and symbol; accept pulses once per stable run.
module tube_input_filter
  import tube_pkg::*;
#(
  parameter int SETTLE_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] seg,
  input  logic [7:0] sel,
  output logic       accept,
  output logic [2:0] pos,
  output symbol_t    sym,
  output logic       sel_bad
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  logic [15:0]   sync1;
  logic [15:0]   sync2;
  logic [15:0]   prev;
  logic [CW-1:0] run_cnt;
  logic [7:0]    prev_seg;
  logic [7:0]    prev_sel;

  // The counter saturates past the accept value so a long dwell accepts only once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      run_cnt <= '0;
    end else begin
      sync1 <= {seg, sel};
      sync2 <= sync1;
      prev  <= sync2;
      if (sync2 != prev) begin
        run_cnt <= '0;
      end else if (run_cnt != CW'(SETTLE_CYCLES)) begin
        run_cnt <= run_cnt + CW'(1);
      end
    end
  end

  // Decode from prev: it holds exactly the value the run counter has vouched for.
  assign prev_seg = prev[15:8];
  assign prev_sel = prev[7:0];
  assign accept   = (run_cnt == CW'(SETTLE_CYCLES - 1));
  assign sel_bad  = ($countones(~prev_sel) != 1);
  assign sym      = decode_seg(prev_seg);

  always_comb begin
    pos = '0;
    for (int i = 0; i < 8; i++) begin
      if (!prev_sel[i]) begin
        pos = 3'(i);
      end
    end
  end

endmodule

// File: rtl/tube_frame_decoder.sv
// Rebuilds state, user sequence and slot mask from the scanned display,
// flags malformed scans and holds the last good frame.
module tube_frame_decoder
  import tube_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 262144
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] seg_in,
  input  logic [7:0] sel_in,
  output logic [3:0] state_out,
  output logic [3:0] seq_out,
  output logic [3:0] slots_out,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [2:0] err_code,
  output logic       locked
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic       accept;
  logic [2:0] pos;
  symbol_t    sym;
  logic       sel_bad;

  tube_input_filter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_filter (
    .CLK    (CLK),
    .RESET  (RESET),
    .seg    (seg_in),
    .sel    (sel_in),
    .accept (accept),
    .pos    (pos),
    .sym    (sym),
    .sel_bad(sel_bad)
  );

  fsm_t          state, state_nx;
  logic [2:0]    exp_pos, exp_nx;
  symbol_t       frame_buf [8];
  symbol_t       buf_nx [8];
  logic [TW-1:0] tmo_cnt, tmo_nx;
  logic [3:0]    state_out_nx, seq_out_nx, slots_out_nx;
  logic          frame_valid_nx, frame_err_nx;
  logic [2:0]    err_code_nx;

  symbol_t       cand [8];
  logic [3:0]    cand_state, cand_seq, cand_slots;
  logic          cand_ok;
  err_t          err;

  // Candidate frame as it would look with the digit now being accepted as B8.
  always_comb begin
    cand       = frame_buf;
    cand[7]    = sym;
    cand_state = '0;
    cand_seq   = '0;
    cand_slots = '0;
    cand_ok    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cand_slots[i] = (cand[i] != MINUS);
      cand_seq[i]   = (cand[i] == ONE);
      cand_state[i] = (cand[4+i] == ONE);
      if (cand[4+i] != ZERO && cand[4+i] != ONE) begin
        cand_ok = 1'b0;
      end
    end
    if (!slot_mask_ok(cand_slots)) begin
      cand_ok = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= HUNT;
      exp_pos     <= '0;
      frame_buf   <= '{default: ZERO};
      tmo_cnt     <= '0;
      state_out   <= '0;
      seq_out     <= '0;
      slots_out   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= '0;
    end else begin
      state       <= state_nx;
      exp_pos     <= exp_nx;
      frame_buf   <= buf_nx;
      tmo_cnt     <= tmo_nx;
      state_out   <= state_out_nx;
      seq_out     <= seq_out_nx;
      slots_out   <= slots_out_nx;
      frame_valid <= frame_valid_nx;
      frame_err   <= frame_err_nx;
      err_code    <= err_code_nx;
    end
  end

  // Error checks are ordered so the highest-priority cause wins within one accept.
  always_comb begin
    state_nx       = state;
    exp_nx         = exp_pos;
    buf_nx         = frame_buf;
    tmo_nx         = tmo_cnt;
    state_out_nx   = state_out;
    seq_out_nx     = seq_out;
    slots_out_nx   = slots_out;
    frame_valid_nx = 1'b0;
    frame_err_nx   = 1'b0;
    err_code_nx    = err_code;
    err            = ERR_NONE;

    case (state)
      HUNT: begin
        tmo_nx = '0;
        if (accept && !sel_bad && pos == 3'd0 && sym != BAD) begin
          buf_nx[0] = sym;
          exp_nx    = 3'd1;
          state_nx  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (accept) begin
          tmo_nx = '0;
          if (sel_bad) begin
            err = ERR_SEL;
          end else if (sym == BAD) begin
            err = ERR_SEG;
          end else if (pos == exp_pos) begin
            buf_nx[pos] = sym;
            exp_nx      = exp_pos + 3'd1;
            if (pos == 3'd7) begin
              if (cand_ok) begin
                state_out_nx   = cand_state;
                seq_out_nx     = cand_seq;
                slots_out_nx   = cand_slots;
                frame_valid_nx = 1'b1;
                err_code_nx    = ERR_NONE;
              end else begin
                err = ERR_FMT;
              end
            end
          end else if (pos == exp_pos - 3'd1) begin
            buf_nx[pos] = sym;
          end else begin
            err = ERR_ORDER;
          end
        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          err = ERR_TIMEOUT;
        end else begin
          tmo_nx = tmo_cnt + TW'(1);
        end

        if (err != ERR_NONE) begin
          frame_err_nx = 1'b1;
          err_code_nx  = err;
          state_nx     = HUNT;
          exp_nx       = '0;
          tmo_nx       = '0;
        end
      end
      default: state_nx = HUNT;
    endcase
  end

  assign locked = (state == CAPTURE);

endmodule

// File: tb/tb_tube_frame_decoder.sv
// Directed bench for tube_frame_decoder: table of full scans plus hand-built
// sequences for mid-scan start, skipped digit, timeout, refresh and reset.
module tb_tube_frame_decoder;

  localparam logic [7:0] D0  = 8'hC0;
  localparam logic [7:0] D1  = 8'hF9;
  localparam logic [7:0] DM  = 8'hBF;
  localparam logic [7:0] DBD = 8'hA4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] seg_in = 8'hFF;
  logic [7:0] sel_in = 8'hFF;
  logic [3:0] state_out, seq_out, slots_out;
  logic       frame_valid, frame_err, locked;
  logic [2:0] err_code;

  int fv_count = 0;
  int fe_count = 0;
  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  tube_frame_decoder #(
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .seg_in     (seg_in),
    .sel_in     (sel_in),
    .state_out  (state_out),
    .seq_out    (seq_out),
    .slots_out  (slots_out),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .locked     (locked)
  );

  // Pulse counters: a pulse held two cycles counts twice.
  always @(negedge CLK) begin
    if (frame_valid) fv_count++;
    if (frame_err) fe_count++;
  end

  typedef struct packed {
    logic [63:0] segs;
    logic [63:0] sels;
    logic [3:0]  fv;
    logic [3:0]  fe;
    logic [2:0]  code;
    logic [3:0]  st;
    logic [3:0]  sq;
    logic [3:0]  sl;
    logic        lk;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [7:0] sel_of(input int p);
    logic [7:0] s;
    s = 8'hFF;
    s[p] = 1'b0;
    return s;
  endfunction

  function automatic logic [63:0] std_sels();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = sel_of(i);
    return v;
  endfunction

  function automatic logic [63:0] scan(input logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8);
    return {b8, b7, b6, b5, b4, b3, b2, b1};
  endfunction

  task automatic apply_stimulus(input logic [7:0] sel, input logic [7:0] seg, input int cycles);
    sel_in = sel;
    seg_in = seg;
    repeat (cycles) @(negedge CLK);
  endtask

  task automatic apply_scan(input logic [63:0] segs, input logic [63:0] sels);
    for (int i = 0; i < 8; i++) apply_stimulus(sels[8*i +: 8], segs[8*i +: 8], 10);
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_frame(input string tag, input int st, input int sq, input int sl);
    check_output({tag, " state_out"}, int'(state_out), st);
    check_output({tag, " seq_out"}, int'(seq_out), sq);
    check_output({tag, " slots_out"}, int'(slots_out), sl);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] case1;
    logic [63:0] bad_sel;
    int fv0, fe0;

    case1   = scan(D1, D0, DM, DM, D1, D0, D1, D0);
    bad_sel = std_sels();
    bad_sel[23:16] = 8'hFC;

    vecs[0] = '{case1, std_sels(), 4'd1, 4'd0, 3'd0, 4'b0101, 4'b0001, 4'b0011, 1'b1};
    vecs[1] = '{case1, std_sels(), 4'd1, 4'd0, 3'd0, 4'b0101, 4'b0001, 4'b0011, 1'b1};
    vecs[2] = '{scan(D0, D0, D0, D0, D0, DBD, D0, D0), std_sels(), 4'd0, 4'd1, 3'd2, 4'b0101, 4'b0001, 4'b0011, 1'b0};
    vecs[3] = '{scan(D0, D0, D0, D0, DM, D0, D0, D0), std_sels(), 4'd0, 4'd1, 3'd4, 4'b0101, 4'b0001, 4'b0011, 1'b0};
    vecs[4] = '{scan(D0, D0, D0, D0, D0, D0, D0, D0), std_sels(), 4'd1, 4'd0, 3'd0, 4'b0000, 4'b0000, 4'b1111, 1'b1};
    vecs[5] = '{scan(DM, DM, DM, DM, D1, D1, D1, D1), std_sels(), 4'd1, 4'd0, 3'd0, 4'b1111, 4'b0000, 4'b0000, 1'b1};
    vecs[6] = '{scan(DM, D1, D0, D0, D0, D0, D0, D0), std_sels(), 4'd0, 4'd1, 3'd4, 4'b1111, 4'b0000, 4'b0000, 1'b0};
    vecs[7] = '{scan(D1, D1, D1, DM, D0, D1, D1, D0), std_sels(), 4'd1, 4'd0, 3'd0, 4'b0110, 4'b0111, 4'b0111, 1'b1};
    vecs[8] = '{scan(D0, D0, D0, D0, D0, D0, D0, D0), bad_sel, 4'd0, 4'd1, 3'd1, 4'b0110, 4'b0111, 4'b0111, 1'b0};
    vecs[9] = '{case1, std_sels(), 4'd1, 4'd0, 3'd0, 4'b0101, 4'b0001, 4'b0011, 1'b1};

    // Reset state
    repeat (3) @(negedge CLK);
    check_frame("reset", 0, 0, 0);
    check_output("reset err_code", int'(err_code), 0);
    check_output("reset locked", int'(locked), 0);
    check_output("reset frame_valid", int'(frame_valid), 0);
    check_output("reset frame_err", int'(frame_err), 0);
    RESET = 1'b0;

    // Start mid-scan at B4, then two full scans
    fv0 = fv_count; fe0 = fe_count;
    for (int p = 3; p < 8; p++) apply_stimulus(sel_of(p), case1[8*p +: 8], 10);
    apply_scan(case1, std_sels());
    apply_scan(case1, std_sels());
    check_output("midscan frame_valid count", fv_count - fv0, 2);
    check_output("midscan frame_err count", fe_count - fe0, 0);
    check_frame("midscan", 4'b0101, 4'b0001, 4'b0011);

    for (int i = 0; i < 10; i++) begin
      fv0 = fv_count; fe0 = fe_count;
      apply_scan(vecs[i].segs, vecs[i].sels);
      check_output($sformatf("v%0d frame_valid count", i), fv_count - fv0, int'(vecs[i].fv));
      check_output($sformatf("v%0d frame_err count", i), fe_count - fe0, int'(vecs[i].fe));
      check_output($sformatf("v%0d err_code", i), int'(err_code), int'(vecs[i].code));
      check_output($sformatf("v%0d locked", i), int'(locked), int'(vecs[i].lk));
      check_frame($sformatf("v%0d", i), int'(vecs[i].st), int'(vecs[i].sq), int'(vecs[i].sl));
    end

    // Skipped digit while locked: B2 then B4
    fv0 = fv_count; fe0 = fe_count;
    apply_stimulus(sel_of(0), D1, 10);
    apply_stimulus(sel_of(1), D0, 10);
    apply_stimulus(sel_of(3), DM, 10);
    check_output("order frame_err count", fe_count - fe0, 1);
    check_output("order err_code", int'(err_code), 3);
    check_output("order locked", int'(locked), 0);
    check_frame("order", 4'b0101, 4'b0001, 4'b0011);

    // Lock, then freeze at B3 past the timeout
    apply_scan(case1, std_sels());
    check_output("pre-timeout locked", int'(locked), 1);
    fv0 = fv_count; fe0 = fe_count;
    apply_stimulus(sel_of(0), D1, 10);
    apply_stimulus(sel_of(1), D0, 10);
    apply_stimulus(sel_of(2), DM, 100);
    check_output("timeout frame_err count", fe_count - fe0, 1);
    check_output("timeout err_code", int'(err_code), 5);
    check_output("timeout locked", int'(locked), 0);
    check_output("timeout frame_valid count", fv_count - fv0, 0);

    // B7 changes value mid-dwell; the frame must carry the later value
    fv0 = fv_count; fe0 = fe_count;
    for (int p = 0; p < 6; p++) apply_stimulus(sel_of(p), case1[8*p +: 8], 10);
    apply_stimulus(sel_of(6), D0, 10);
    apply_stimulus(sel_of(6), D1, 10);
    apply_stimulus(sel_of(7), D0, 10);
    check_output("refresh frame_valid count", fv_count - fv0, 1);
    check_output("refresh frame_err count", fe_count - fe0, 0);
    check_output("refresh err_code", int'(err_code), 0);
    check_frame("refresh", 4'b0101, 4'b0001, 4'b0011);

    // Reset during B5 of a locked scan
    for (int p = 0; p < 4; p++) apply_stimulus(sel_of(p), case1[8*p +: 8], 10);
    apply_stimulus(sel_of(4), D1, 3);
    RESET = 1'b1;
    #1;
    check_frame("midreset", 0, 0, 0);
    check_output("midreset locked", int'(locked), 0);
    check_output("midreset err_code", int'(err_code), 0);
    @(negedge CLK);
    RESET = 1'b0;
    fv0 = fv_count; fe0 = fe_count;
    apply_scan(case1, std_sels());
    check_output("post-reset frame_valid count", fv_count - fv0, 1);
    check_output("post-reset frame_err count", fe_count - fe0, 0);
    check_output("post-reset locked", int'(locked), 1);
    check_frame("post-reset", 4'b0101, 4'b0001, 4'b0011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
